tick_stopwatch: RTL and testbench

- Consumes the slow square wave from the frequency divider (50 MHz iClk, toggling every 25,000,001 cycles, about 1 Hz) and turns each rising edge into one-second ticks.
- Keeps a BCD MM:SS stopwatch, 00:00 to 59:59, with start/stop/clear control.
- Drives the board display stage and status LEDs.

---
 rtl/tick_stopwatch.sv | 185 ++++++++++++++++++
 tb/tb_tick_stopwatch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_stopwatch.sv
// BCD MM:SS stopwatch advanced by rising edges of an asynchronous ~1 Hz square wave.
// Optional seven-segment drivers are built when TICK_STOPWATCH_SEVEN_SEG_EN is defined.
`timescale 1ns/1ps
module tick_stopwatch #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 59
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iSlow,
  input  logic       iStart,
  input  logic       iStop,
  input  logic       iClear,
  output logic [3:0] oSecOnes,
  output logic [3:0] oSecTens,
  output logic [3:0] oMinOnes,
  output logic [3:0] oMinTens,
  output logic       oTick,
  output logic       oWrap,
  output logic       oRunning
`ifdef TICK_STOPWATCH_SEVEN_SEG_EN
  ,
  output logic [6:0] oSeg0,
  output logic [6:0] oSeg1,
  output logic [6:0] oSeg2,
  output logic [6:0] oSeg3
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} stateT;

  localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   edgeReg;
  logic                   rise;
  stateT                  stateReg, stateNext;
  logic                   countEn;
  logic                   atMax;
  logic [3:0]             secOnesReg, secTensReg, minOnesReg, minTensReg;
  logic [3:0]             secOnesNext, secTensNext, minOnesNext, minTensNext;
  logic                   wrapNext;
  logic                   tickReg, wrapReg;

  // Synchronizer chain for the asynchronous divider output.
  generate
    if (SYNC_STAGES == 1) begin : gSyncOne
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) syncReg <= '0;
        else         syncReg <= iSlow;
      end
    end else begin : gSyncMulti
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) syncReg <= '0;
        else         syncReg <= {syncReg[SYNC_STAGES-2:0], iSlow};
      end
    end
  endgenerate

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) edgeReg <= 1'b0;
    else         edgeReg <= syncReg[SYNC_STAGES-1];
  end

  assign rise = syncReg[SYNC_STAGES-1] & ~edgeReg;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) stateReg <= IDLE;
    else         stateReg <= stateNext;
  end

  // Clear beats stop beats start; a stop in IDLE/PAUSE also masks a start.
  always_comb begin
    stateNext = stateReg;
    if (iClear) begin
      stateNext = IDLE;
    end else if (iStop) begin
      if (stateReg == RUN) stateNext = PAUSE;
    end else if (iStart && stateReg != RUN) begin
      stateNext = RUN;
    end
  end

  assign countEn = (stateReg == RUN) && rise && !iClear && !iStop;
  assign atMax   = (minTensReg == MAX_MIN_TENS) && (minOnesReg == MAX_MIN_ONES) &&
                   (secTensReg == 4'd5) && (secOnesReg == 4'd9);

  always_comb begin
    secOnesNext = secOnesReg;
    secTensNext = secTensReg;
    minOnesNext = minOnesReg;
    minTensNext = minTensReg;
    wrapNext    = 1'b0;
    if (iClear) begin
      secOnesNext = 4'd0;
      secTensNext = 4'd0;
      minOnesNext = 4'd0;
      minTensNext = 4'd0;
    end else if (countEn) begin
      if (atMax) begin
        secOnesNext = 4'd0;
        secTensNext = 4'd0;
        minOnesNext = 4'd0;
        minTensNext = 4'd0;
        wrapNext    = 1'b1;
      end else if (secOnesReg != 4'd9) begin
        secOnesNext = secOnesReg + 4'd1;
      end else begin
        secOnesNext = 4'd0;
        if (secTensReg != 4'd5) begin
          secTensNext = secTensReg + 4'd1;
        end else begin
          secTensNext = 4'd0;
          if (minOnesReg != 4'd9) begin
            minOnesNext = minOnesReg + 4'd1;
          end else begin
            minOnesNext = 4'd0;
            minTensNext = minTensReg + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      secOnesReg <= 4'd0;
      secTensReg <= 4'd0;
      minOnesReg <= 4'd0;
      minTensReg <= 4'd0;
      tickReg    <= 1'b0;
      wrapReg    <= 1'b0;
    end else begin
      secOnesReg <= secOnesNext;
      secTensReg <= secTensNext;
      minOnesReg <= minOnesNext;
      minTensReg <= minTensNext;
      tickReg    <= countEn;
      wrapReg    <= wrapNext;
    end
  end

  assign oSecOnes = secOnesReg;
  assign oSecTens = secTensReg;
  assign oMinOnes = minOnesReg;
  assign oMinTens = minTensReg;
  assign oTick    = tickReg;
  assign oWrap    = wrapReg;
  assign oRunning = (stateReg == RUN);

`ifdef TICK_STOPWATCH_SEVEN_SEG_EN
  // Active-low gfedcba; anything outside 0-9 is blanked.
  function automatic logic [6:0] segDecode(input logic [3:0] digit);
    case (digit)
      4'd0:    segDecode = 7'b1000000;
      4'd1:    segDecode = 7'b1111001;
      4'd2:    segDecode = 7'b0100100;
      4'd3:    segDecode = 7'b0110000;
      4'd4:    segDecode = 7'b0011001;
      4'd5:    segDecode = 7'b0010010;
      4'd6:    segDecode = 7'b0000010;
      4'd7:    segDecode = 7'b1111000;
      4'd8:    segDecode = 7'b0000000;
      4'd9:    segDecode = 7'b0010000;
      default: segDecode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oSeg0 <= 7'b1000000;
      oSeg1 <= 7'b1000000;
      oSeg2 <= 7'b1000000;
      oSeg3 <= 7'b1000000;
    end else begin
      oSeg0 <= segDecode(secOnesReg);
      oSeg1 <= segDecode(secTensReg);
      oSeg2 <= segDecode(minOnesReg);
      oSeg3 <= segDecode(minTensReg);
    end
  end
`endif

endmodule

// File: tb/tb_tick_stopwatch.sv
// Scoreboard bench for tick_stopwatch: one instance with MAX_MIN=59, one with MAX_MIN=1,
// both driven by the same stimulus; expected ticks are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_tick_stopwatch;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rstN, slow, start, stop, clr;
  logic [3:0] aSO, aST, aMO, aMT, bSO, bST, bMO, bMT;
  logic aTick, aWrap, aRun, bTick, bWrap, bRun;
`ifdef TICK_STOPWATCH_SEVEN_SEG_EN
  logic [6:0] aSeg0, aSeg1, aSeg2, aSeg3, bSeg0, bSeg1, bSeg2, bSeg3;
`endif

  tick_stopwatch #(.SYNC_STAGES(2), .MAX_MIN(59)) dutA (
    .iClk(clk), .iRst_n(rstN), .iSlow(slow), .iStart(start), .iStop(stop), .iClear(clr),
    .oSecOnes(aSO), .oSecTens(aST), .oMinOnes(aMO), .oMinTens(aMT),
    .oTick(aTick), .oWrap(aWrap), .oRunning(aRun)
`ifdef TICK_STOPWATCH_SEVEN_SEG_EN
    , .oSeg0(aSeg0), .oSeg1(aSeg1), .oSeg2(aSeg2), .oSeg3(aSeg3)
`endif
  );

  tick_stopwatch #(.SYNC_STAGES(2), .MAX_MIN(1)) dutB (
    .iClk(clk), .iRst_n(rstN), .iSlow(slow), .iStart(start), .iStop(stop), .iClear(clr),
    .oSecOnes(bSO), .oSecTens(bST), .oMinOnes(bMO), .oMinTens(bMT),
    .oTick(bTick), .oWrap(bWrap), .oRunning(bRun)
`ifdef TICK_STOPWATCH_SEVEN_SEG_EN
    , .oSeg0(bSeg0), .oSeg1(bSeg1), .oSeg2(bSeg2), .oSeg3(bSeg3)
`endif
  );

  typedef struct packed {
    logic [15:0] t;
    logic        w;
    logic [31:0] raise;
  } expT;

  expT qA[$];
  expT qB[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cycleCnt   = 0;
  int  secsA      = 0;
  int  secsB      = 0;
  bit  modelRun   = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Monitor: every oTick pops one expected entry per instance.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (aTick) begin
          if (qA.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL A unexpected tick: got %h, expected no tick", {aMT, aMO, aST, aSO});
          end else begin
            e = qA.pop_front();
            $display("tick A %h wrap %b", {aMT, aMO, aST, aSO}, aWrap);
            chk("A time", {16'd0, aMT, aMO, aST, aSO}, {16'd0, e.t});
            chk("A wrap", {31'd0, aWrap}, {31'd0, e.w});
            chk("A latency", cycleCnt - e.raise, 32'd3);
          end
        end else if (aWrap) begin
          compared++; mismatched++;
          $display("FAIL A wrap without tick: got 1, expected 0");
        end
        if (bTick) begin
          if (qB.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL B unexpected tick: got %h, expected no tick", {bMT, bMO, bST, bSO});
          end else begin
            e = qB.pop_front();
            $display("tick B %h wrap %b", {bMT, bMO, bST, bSO}, bWrap);
            chk("B time", {16'd0, bMT, bMO, bST, bSO}, {16'd0, e.t});
            chk("B wrap", {31'd0, bWrap}, {31'd0, e.w});
            chk("B latency", cycleCnt - e.raise, 32'd3);
          end
        end else if (bWrap) begin
          compared++; mismatched++;
          $display("FAIL B wrap without tick: got 1, expected 0");
        end
      end
    end
  end

  task automatic pulseStart();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    modelRun = 1;
  endtask

  task automatic pulseClear();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    modelRun = 0; secsA = 0; secsB = 0;
  endtask

  // mode 0: plain edge; 1: iStop in the rise cycle; 2: iClear+iStart in the rise cycle
  task automatic doTick(input int mode);
    expT e;
    @(negedge clk);
    slow = 1'b1;
    if (mode == 0 && modelRun) begin
      secsA = (secsA + 1) % 3600;
      secsB = (secsB + 1) % 120;
      e.raise = cycleCnt;
      e.t = bcd(secsA); e.w = (secsA == 0); qA.push_back(e);
      e.t = bcd(secsB); e.w = (secsB == 0); qB.push_back(e);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    if (mode == 1) stop = 1'b1;
    if (mode == 2) begin clr = 1'b1; start = 1'b1; end
    @(posedge clk);
    #1;
    stop = 1'b0; clr = 1'b0; start = 1'b0;
    if (mode == 1) modelRun = 0;
    if (mode == 2) begin modelRun = 0; secsA = 0; secsB = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    slow = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rstN = 1'b0; slow = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset A", {13'd0, aMT, aMO, aST, aSO, aTick, aWrap, aRun}, 32'd0);
    chk("reset B", {13'd0, bMT, bMO, bST, bSO, bTick, bWrap, bRun}, 32'd0);
`ifdef TICK_STOPWATCH_SEVEN_SEG_EN
    chk("reset segA", {4'd0, aSeg3, aSeg2, aSeg1, aSeg0}, {4'd0, {4{7'b1000000}}});
`endif
    @(negedge clk); rstN = 1'b1;
    repeat (2) @(negedge clk);

    pulseStart();
    chk("A running", {31'd0, aRun}, 32'd1);
    repeat (3) doTick(0);
    chk("A 00:03", {16'd0, aMT, aMO, aST, aSO}, 32'h0003);
    chk("A still running", {31'd0, aRun}, 32'd1);

    repeat (56) doTick(0);
    chk("A 00:59", {16'd0, aMT, aMO, aST, aSO}, 32'h0059);
    doTick(0);
    chk("A 01:00", {16'd0, aMT, aMO, aST, aSO}, 32'h0100);
    chk("B 01:00", {16'd0, bMT, bMO, bST, bSO}, 32'h0100);
    repeat (59) doTick(0);
    chk("B 01:59", {16'd0, bMT, bMO, bST, bSO}, 32'h0159);
    doTick(0);
    chk("A 02:00", {16'd0, aMT, aMO, aST, aSO}, 32'h0200);
    chk("B wrapped 00:00", {16'd0, bMT, bMO, bST, bSO}, 32'h0000);
    chk("B running after wrap", {31'd0, bRun}, 32'd1);

    pulseClear();
    pulseStart();
    repeat (5) doTick(0);
    chk("A 00:05", {16'd0, aMT, aMO, aST, aSO}, 32'h0005);
`ifdef TICK_STOPWATCH_SEVEN_SEG_EN
    chk("segA0 glyph 5", {25'd0, aSeg0}, {25'd0, 7'b0010010});
`endif
    doTick(1);
    chk("A held at stop", {16'd0, aMT, aMO, aST, aSO}, 32'h0005);
    chk("A paused", {31'd0, aRun}, 32'd0);
    repeat (4) doTick(0);
    chk("A held in pause", {16'd0, aMT, aMO, aST, aSO}, 32'h0005);
    pulseStart();
    doTick(0);
    chk("A 00:06", {16'd0, aMT, aMO, aST, aSO}, 32'h0006);
    doTick(0);
    chk("A 00:07", {16'd0, aMT, aMO, aST, aSO}, 32'h0007);

    doTick(2);
    chk("A cleared", {16'd0, aMT, aMO, aST, aSO}, 32'h0000);
    chk("A idle after clear", {31'd0, aRun}, 32'd0);
    repeat (2) doTick(0);
    chk("A idle no count", {16'd0, aMT, aMO, aST, aSO}, 32'h0000);

    pulseStart();
    repeat (754) doTick(0);
    chk("A 12:34", {16'd0, aMT, aMO, aST, aSO}, 32'h1234);
    chk("B 00:34", {16'd0, bMT, bMO, bST, bSO}, 32'h0034);
    chk("A pending ticks", qA.size(), 32'd0);
    chk("B pending ticks", qB.size(), 32'd0);

    @(posedge clk);
    #3 rstN = 1'b0;
    #2;
    chk("async reset A", {13'd0, aMT, aMO, aST, aSO, aTick, aWrap, aRun}, 32'd0);
    chk("async reset B", {13'd0, bMT, bMO, bST, bSO, bTick, bWrap, bRun}, 32'd0);
`ifdef TICK_STOPWATCH_SEVEN_SEG_EN
    chk("async reset segA", {4'd0, aSeg3, aSeg2, aSeg1, aSeg0}, {4'd0, {4{7'b1000000}}});
    chk("async reset segB", {4'd0, bSeg3, bSeg2, bSeg1, bSeg0}, {4'd0, {4{7'b1000000}}});
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
